// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state codes and default timing for the stopwatch controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'b00,
    SW_RUN   = 2'b01,
    SW_PAUSE = 2'b10,
    SW_LAP   = 2'b11
  } sw_state_e;

  // 100 Hz count rate from a 100 MHz clock
  localparam int SW_TICK_DIV = 1_000_000;
  localparam int SW_PRESC_W  = 20;

  // Prescaler keeps running while the count is live (RUN or LAP view)
  function automatic logic sw_counting(input sw_state_e s);
    return (s == SW_RUN) || (s == SW_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_one_pulse.sv
// Rising-edge detector: turns a debounced button level into a one-cycle pulse.
// Latency: pulse is registered, high the cycle after the level first goes high.
// Backpressure: none; a held level yields exactly one pulse.
module stopwatch_ctrl_one_pulse
  import stopwatch_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_lvl,
  output logic out_pulse
);

  logic hist;

  // History resets high so a button held through reset release produces no pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist      <= 1'b1;
      out_pulse <= 1'b0;
    end else begin
      hist      <= in_lvl;
      out_pulse <= in_lvl & ~hist;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/lap state, tick prescaler, counter/display strobes.
// Latency: button level -> new state two cycles later; all outputs registered.
// Backpressure: none; the counter datapath must accept a tick or clear on any cycle.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = SW_TICK_DIV,
  parameter int PRESC_W  = SW_PRESC_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic       count_tick,
  output logic       count_clr,
  output logic       disp_hold,
  output logic [1:0] state_o
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  sw_state_e          state, next_state;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic               start_p, lap_p;
  logic               clr_nxt;
  logic               tick_nxt;

  stopwatch_ctrl_one_pulse u_start_pulse (
    .clk       (clk),
    .rst       (rst),
    .in_lvl    (btn_start),
    .out_pulse (start_p)
  );

  stopwatch_ctrl_one_pulse u_lap_pulse (
    .clk       (clk),
    .rst       (rst),
    .in_lvl    (btn_lap),
    .out_pulse (lap_p)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SW_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start always takes priority over lap
  always_comb begin
    next_state = state;
    clr_nxt    = 1'b0;
    case (state)
      SW_IDLE: begin
        if (start_p) next_state = SW_RUN;
      end
      SW_RUN: begin
        if (start_p)    next_state = SW_PAUSE;
        else if (lap_p) next_state = SW_LAP;
      end
      SW_PAUSE: begin
        if (start_p) begin
          next_state = SW_RUN;
        end else if (lap_p) begin
          next_state = SW_IDLE;
          clr_nxt    = 1'b1;
        end
      end
      SW_LAP: begin
        if (start_p)    next_state = SW_PAUSE;
        else if (lap_p) next_state = SW_RUN;
      end
      default: next_state = SW_IDLE;
    endcase
  end

  // Prescaler next value: zero in IDLE, frozen in PAUSE so the fractional period survives
  always_comb begin
    presc_nxt = presc;
    tick_nxt  = 1'b0;
    if (state == SW_IDLE) begin
      presc_nxt = '0;
    end else if (sw_counting(state)) begin
      if (presc == PRESC_MAX) begin
        presc_nxt = '0;
        tick_nxt  = 1'b1;
      end else begin
        presc_nxt = presc + 1'b1;
      end
    end
  end

  // Prescaler register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else begin
      presc <= presc_nxt;
    end
  end

  // Output strobes; a tick earned on the last counting cycle still fires the cycle after
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_tick <= 1'b0;
      count_clr  <= 1'b0;
      disp_hold  <= 1'b0;
    end else begin
      count_tick <= tick_nxt;
      count_clr  <= clr_nxt;
      disp_hold  <= (next_state == SW_LAP);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Expected values are hand-derived cycle by cycle.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       count_tick;
  logic       count_clr;
  logic       disp_hold;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.TICK_DIV(4), .PRESC_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .btn_lap    (btn_lap),
    .count_tick (count_tick),
    .count_clr  (count_clr),
    .disp_hold  (disp_hold),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Hold the given buttons high for one cycle, then release; returns in the pulse cycle
  task automatic press(input logic s, input logic l);
    btn_start = s;
    btn_lap   = l;
    step();
    btn_start = 1'b0;
    btn_lap   = 1'b0;
  endtask

  task automatic do_reset;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Reset puts the design in IDLE with all strobes low; a start press then enters RUN at k
  task automatic start_run;
    do_reset();
    press(1'b1, 1'b0);
    step();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    checks++; if (count_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", count_tick); end
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL reset_clr got %b want 0", count_clr); end
    checks++; if (disp_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", disp_hold); end
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state_o); end
    rst = 1'b0;
    step();
    step();
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL post_reset_state got %b want 00", state_o); end
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL post_reset_clr got %b want 0", count_clr); end
  endtask

  task automatic test_run_ticks;
    logic exp;
    do_reset();
    btn_start = 1'b1;
    step();
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL start_pulse_state got %b want 00", state_o); end
    btn_start = 1'b0;
    step();
    for (int i = 0; i < 14; i++) begin
      exp = (i == 4) || (i == 8) || (i == 12);
      checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL run_state[%0d] got %b want 01", i, state_o); end
      checks++; if (count_tick !== exp) begin errors++; $display("FAIL run_tick[%0d] got %b want %b", i, count_tick, exp); end
      step();
    end
  endtask

  task automatic test_pause_resume;
    start_run();
    press(1'b1, 1'b0);
    step();
    checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL pause_state got %b want 10", state_o); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (count_tick !== 1'b0) begin errors++; $display("FAIL pause_tick[%0d] got %b want 0", i, count_tick); end
      step();
    end
    checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL pause_state_end got %b want 10", state_o); end
    press(1'b1, 1'b0);
    step();
    checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL resume_state got %b want 01", state_o); end
    checks++; if (count_tick !== 1'b0) begin errors++; $display("FAIL resume_tick0 got %b want 0", count_tick); end
    step();
    checks++; if (count_tick !== 1'b0) begin errors++; $display("FAIL resume_tick1 got %b want 0", count_tick); end
    step();
    checks++; if (count_tick !== 1'b1) begin errors++; $display("FAIL resume_tick2 got %b want 1", count_tick); end
    step();
    checks++; if (count_tick !== 1'b0) begin errors++; $display("FAIL resume_tick3 got %b want 0", count_tick); end
  endtask

  task automatic test_lap;
    logic exp;
    start_run();
    press(1'b0, 1'b1);
    checks++; if (disp_hold !== 1'b0) begin errors++; $display("FAIL lap_hold_early got %b want 0", disp_hold); end
    step();
    checks++; if (state_o !== 2'b11) begin errors++; $display("FAIL lap_state got %b want 11", state_o); end
    for (int j = 2; j <= 8; j++) begin
      exp = (j == 4) || (j == 8);
      checks++; if (disp_hold !== 1'b1) begin errors++; $display("FAIL lap_hold[%0d] got %b want 1", j, disp_hold); end
      checks++; if (count_tick !== exp) begin errors++; $display("FAIL lap_tick[%0d] got %b want %b", j, count_tick, exp); end
      step();
    end
    press(1'b0, 1'b1);
    checks++; if (disp_hold !== 1'b1) begin errors++; $display("FAIL unlap_hold_pulse got %b want 1", disp_hold); end
    step();
    checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL unlap_state got %b want 01", state_o); end
    checks++; if (disp_hold !== 1'b0) begin errors++; $display("FAIL unlap_hold got %b want 0", disp_hold); end
    checks++; if (count_tick !== 1'b0) begin errors++; $display("FAIL unlap_tick11 got %b want 0", count_tick); end
    step();
    checks++; if (count_tick !== 1'b1) begin errors++; $display("FAIL unlap_tick12 got %b want 1", count_tick); end
  endtask

  task automatic test_clear;
    logic exp;
    start_run();
    press(1'b1, 1'b0);
    step();
    checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL clr_pause_state got %b want 10", state_o); end
    press(1'b0, 1'b1);
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL clr_early got %b want 0", count_clr); end
    step();
    checks++; if (count_clr !== 1'b1) begin errors++; $display("FAIL clr_strobe got %b want 1", count_clr); end
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL clr_state got %b want 00", state_o); end
    step();
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL clr_late got %b want 0", count_clr); end
    press(1'b1, 1'b0);
    step();
    checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL clr_restart_state got %b want 01", state_o); end
    for (int i = 0; i <= 4; i++) begin
      exp = (i == 4);
      checks++; if (count_tick !== exp) begin errors++; $display("FAIL clr_restart_tick[%0d] got %b want %b", i, count_tick, exp); end
      step();
    end
  endtask

  task automatic test_both_buttons;
    start_run();
    press(1'b1, 1'b1);
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL both_clr1 got %b want 0", count_clr); end
    step();
    checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL both_state got %b want 10", state_o); end
    checks++; if (disp_hold !== 1'b0) begin errors++; $display("FAIL both_hold got %b want 0", disp_hold); end
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL both_clr2 got %b want 0", count_clr); end
    step();
    checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL both_state_late got %b want 10", state_o); end
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL both_clr3 got %b want 0", count_clr); end
  endtask

  task automatic test_reset_cases;
    rst = 1'b1;
    btn_start = 1'b1;
    btn_lap = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL held_start_state[%0d] got %b want 00", i, state_o); end
    end
    btn_start = 1'b0;
    step();
    press(1'b1, 1'b0);
    step();
    checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL mid_run_state got %b want 01", state_o); end
    press(1'b0, 1'b1);
    step();
    step();
    step();
    checks++; if (count_tick !== 1'b1) begin errors++; $display("FAIL mid_tick_pre got %b want 1", count_tick); end
    checks++; if (disp_hold !== 1'b1) begin errors++; $display("FAIL mid_hold_pre got %b want 1", disp_hold); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (count_tick !== 1'b0) begin errors++; $display("FAIL async_tick got %b want 0", count_tick); end
    checks++; if (disp_hold !== 1'b0) begin errors++; $display("FAIL async_hold got %b want 0", disp_hold); end
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL async_clr got %b want 0", count_clr); end
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL async_state got %b want 00", state_o); end
    step();
    rst = 1'b0;
    step();
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL after_async_state got %b want 00", state_o); end
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL after_async_clr got %b want 0", count_clr); end
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_pause_resume();
    test_lap();
    test_clear();
    test_both_buttons();
    test_reset_cases();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
